// File: rtl/nand_pkg.sv
// ----------------------------------------------------------------------------
// nand_pkg
// Shared constants and types for the nand_gate block.
//   DEF_WIDTH / DEF_CNT_W : default operand width and pattern-counter width.
//   pat_e                 : lane-0 input pattern {a[0], b[0]}, used to index
//                           the four coverage counters.
// ----------------------------------------------------------------------------
package nand_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        PAT_00 = 2'b00,
        PAT_01 = 2'b01,
        PAT_10 = 2'b10,
        PAT_11 = 2'b11
    } pat_e;

    localparam int NUM_PAT = 4;

endpackage : nand_pkg

// File: rtl/nand_gate_if.sv
// ----------------------------------------------------------------------------
// nand_gate_if
// Groups the operand, qualifier and result signals of nand_gate.
//   a, b       : operands (WIDTH bits)
//   in_valid   : qualifies a/b for the registered path and the counters
//   clr_cnt    : synchronous clear of all pattern counters
//   y          : combinational ~(a & b)
//   y_q        : registered NAND result
//   out_valid  : in_valid delayed one cycle
//   cnt_00..11 : saturating hit counts of the lane-0 pattern {a[0], b[0]}
// The master modport drives operands; the slave modport is the gate itself.
// ----------------------------------------------------------------------------
interface nand_gate_if
    import nand_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             clr_cnt;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;
    logic [CNT_W-1:0] cnt_00;
    logic [CNT_W-1:0] cnt_01;
    logic [CNT_W-1:0] cnt_10;
    logic [CNT_W-1:0] cnt_11;

    modport master (
        output a, b, in_valid, clr_cnt,
        input  y, y_q, out_valid, cnt_00, cnt_01, cnt_10, cnt_11
    );

    modport slave (
        input  a, b, in_valid, clr_cnt,
        output y, y_q, out_valid, cnt_00, cnt_01, cnt_10, cnt_11
    );

endinterface : nand_gate_if

// File: rtl/nand_sat_counter.sv
// ----------------------------------------------------------------------------
// nand_sat_counter
// CNT_W-bit up counter that sticks at its maximum value instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : add one on this edge (ignored once saturated)
//   clr   : synchronous clear; wins over a simultaneous inc
//   count : current value
// ----------------------------------------------------------------------------
module nand_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : nand_sat_counter

// File: rtl/nand_gate.sv
// ----------------------------------------------------------------------------
// nand_gate
// Bitwise NAND with a one-stage registered copy and lane-0 coverage counters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (y_q -> all ones, out_valid -> 0,
//           counters -> 0); y is unaffected by reset
//   bus   : nand_gate_if slave modport (operands, results, counters)
// y is purely combinational. y_q loads the NAND result on valid edges and
// holds otherwise. Each valid edge bumps the counter selected by
// {a[0], b[0]}; clr_cnt zeroes all counters and drops that cycle's hit.
// ----------------------------------------------------------------------------
module nand_gate
    import nand_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    nand_gate_if.slave  bus
);

    logic [WIDTH-1:0] nand_val;
    logic [WIDTH-1:0] y_q_r;
    logic             out_valid_r;
    pat_e             pat;
    logic [NUM_PAT-1:0] hit;
    logic [CNT_W-1:0] cnt [NUM_PAT];

    // NAND lanes: zero latency, independent of clock, reset and qualifiers.
    assign nand_val = ~(bus.a & bus.b);
    assign bus.y    = nand_val;

    // Registered path: y_q resets to all ones, matching NAND of all-zero
    // operands, so downstream logic sees a legal value before the first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r       <= '1;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                y_q_r <= nand_val;
            end
        end
    end

    assign bus.y_q       = y_q_r;
    assign bus.out_valid = out_valid_r;

    // Pattern decode. An unknown a[0]/b[0] matches no item and falls to the
    // default, so no counter moves on X operands.
    assign pat = pat_e'({bus.a[0], bus.b[0]});

    // NOTE: combinational blocks assign every output a default first so no
    // path through the block leaves a value unassigned (no latch).
    always_comb begin
        hit = '0;
        if (bus.in_valid) begin
            case (pat)
                PAT_00:  hit[PAT_00] = 1'b1;
                PAT_01:  hit[PAT_01] = 1'b1;
                PAT_10:  hit[PAT_10] = 1'b1;
                PAT_11:  hit[PAT_11] = 1'b1;
                default: hit = '0;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_cnt
        nand_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (hit[i]),
            .clr   (bus.clr_cnt),
            .count (cnt[i])
        );
    end

    assign bus.cnt_00 = cnt[PAT_00];
    assign bus.cnt_01 = cnt[PAT_01];
    assign bus.cnt_10 = cnt[PAT_10];
    assign bus.cnt_11 = cnt[PAT_11];

endmodule : nand_gate

// File: tb/tb_nand_gate.sv
// ----------------------------------------------------------------------------
// tb_nand_gate
// Self-checking bench for nand_gate. Two instances share clk/rst_n:
//   u_base : WIDTH = 1, CNT_W = 16 (truth table, registered path, coverage)
//   u_wide : WIDTH = 8, CNT_W = 2  (wide operands, counter saturation)
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// the edge or 1 ns after an input change.
// ----------------------------------------------------------------------------
module tb_nand_gate;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    nand_gate_if #(.WIDTH(1), .CNT_W(16)) bus_b ();
    nand_gate_if #(.WIDTH(8), .CNT_W(2))  bus_w ();

    nand_gate #(.WIDTH(1), .CNT_W(16)) u_base (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    nand_gate #(.WIDTH(8), .CNT_W(2)) u_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_base_cnts(input string tag, input int c00, input int c01,
                                   input int c10, input int c11);
        check({tag, " cnt_00"}, 64'(bus_b.cnt_00), 64'(c00));
        check({tag, " cnt_01"}, 64'(bus_b.cnt_01), 64'(c01));
        check({tag, " cnt_10"}, 64'(bus_b.cnt_10), 64'(c10));
        check({tag, " cnt_11"}, 64'(bus_b.cnt_11), 64'(c11));
    endtask

    // Truth-table vectors (in_valid = 0).
    typedef struct {
        logic a;
        logic b;
        logic exp_y;
    } tt_t;

    // Clocked vectors: inputs for one edge plus expected state after it.
    typedef struct {
        logic a;
        logic b;
        logic v;
        logic clr;
        logic exp_y;
        logic exp_yq;
        logic exp_ov;
        int   c00;
        int   c01;
        int   c10;
        int   c11;
    } vec_t;

    tt_t  tt  [4];
    vec_t tbl [11];

    initial begin
        tt[0] = '{1'b0, 1'b0, 1'b1};
        tt[1] = '{1'b0, 1'b1, 1'b1};
        tt[2] = '{1'b1, 1'b0, 1'b1};
        tt[3] = '{1'b1, 1'b1, 1'b0};

        //          a     b     v     clr   y     yq    ov    c00 c01 c10 c11
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0,  0,  1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0,  1,  0,  1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,  0,  0,  0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,  0,  0,  0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,  1,  0,  0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,  1,  1,  0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1,  1,  1,  1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1,  1,  1,  2};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0,  0,  0,  0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  0,  0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0,  0,  1,  0};

        // Bring registers to a known non-reset value, then reset between edges.
        rst_n          = 1'b1;
        bus_b.a        = 1'b1;
        bus_b.b        = 1'b1;
        bus_b.in_valid = 1'b1;
        bus_b.clr_cnt  = 1'b0;
        bus_w.a        = 8'h00;
        bus_w.b        = 8'h00;
        bus_w.in_valid = 1'b0;
        bus_w.clr_cnt  = 1'b0;
        repeat (2) edge_step();
        check("pre-reset y_q", 64'(bus_b.y_q), 64'h0);

        #2;
        rst_n = 1'b0;
        #1;
        check("async reset y_q", 64'(bus_b.y_q), 64'h1);
        check("async reset out_valid", 64'(bus_b.out_valid), 64'h0);
        check_base_cnts("async reset", 0, 0, 0, 0);
        check("async reset wide y_q", 64'(bus_w.y_q), 64'hFF);
        check("y during reset", 64'(bus_b.y), 64'h0);

        bus_b.in_valid = 1'b0;
        bus_b.a        = 1'b0;
        bus_b.b        = 1'b0;
        #1;
        check("y follows a/b in reset", 64'(bus_b.y), 64'h1);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-release y_q held", 64'(bus_b.y_q), 64'h1);
        check("post-release out_valid held", 64'(bus_b.out_valid), 64'h0);

        // Truth table with in_valid low: y only, registered side untouched.
        for (int i = 0; i < 4; i++) begin
            bus_b.a = tt[i].a;
            bus_b.b = tt[i].b;
            #1;
            check($sformatf("truth y[%0d]", i), 64'(bus_b.y), 64'(tt[i].exp_y));
            #9;
        end
        check("truth y_q idle", 64'(bus_b.y_q), 64'h1);
        check_base_cnts("truth idle", 0, 0, 0, 0);

        // Registered path, coverage stream and clr_cnt priority.
        edge_step();
        for (int i = 0; i < 11; i++) begin
            bus_b.a        = tbl[i].a;
            bus_b.b        = tbl[i].b;
            bus_b.in_valid = tbl[i].v;
            bus_b.clr_cnt  = tbl[i].clr;
            #1;
            check($sformatf("vec%0d y", i), 64'(bus_b.y), 64'(tbl[i].exp_y));
            edge_step();
            check($sformatf("vec%0d y_q", i), 64'(bus_b.y_q), 64'(tbl[i].exp_yq));
            check($sformatf("vec%0d out_valid", i), 64'(bus_b.out_valid), 64'(tbl[i].exp_ov));
            check_base_cnts($sformatf("vec%0d", i), tbl[i].c00, tbl[i].c01, tbl[i].c10, tbl[i].c11);
        end
        bus_b.in_valid = 1'b0;
        bus_b.clr_cnt  = 1'b0;

        // Wide operands on the 8-bit instance.
        bus_w.a        = 8'hF0;
        bus_w.b        = 8'hCC;
        bus_w.in_valid = 1'b1;
        #1;
        check("wide y", 64'(bus_w.y), 64'h3F);
        edge_step();
        check("wide y_q", 64'(bus_w.y_q), 64'h3F);
        check("wide out_valid", 64'(bus_w.out_valid), 64'h1);
        check("wide cnt_00", 64'(bus_w.cnt_00), 64'h1);

        // Saturation on the 2-bit counters: lane 0 = {1,0}.
        bus_w.a = 8'h01;
        bus_w.b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            check($sformatf("sat cnt_10 step%0d", i), 64'(bus_w.cnt_10),
                  64'((i + 1 > 3) ? 3 : i + 1));
        end
        check("sat y_q", 64'(bus_w.y_q), 64'hFF);
        check("sat cnt_00 untouched", 64'(bus_w.cnt_00), 64'h1);

        // Async reset mid-stream with in_valid high on both instances.
        bus_b.a        = 1'b1;
        bus_b.b        = 1'b1;
        bus_b.in_valid = 1'b1;
        edge_step();
        check("mid y_q before reset", 64'(bus_b.y_q), 64'h0);
        check("mid cnt_11 before reset", 64'(bus_b.cnt_11), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset y_q", 64'(bus_b.y_q), 64'h1);
        check("mid reset out_valid", 64'(bus_b.out_valid), 64'h0);
        check_base_cnts("mid reset", 0, 0, 0, 0);
        check("mid reset wide cnt_10", 64'(bus_w.cnt_10), 64'h0);
        check("mid reset wide out_valid", 64'(bus_w.out_valid), 64'h0);
        check("mid reset y", 64'(bus_b.y), 64'h0);
        bus_b.a = 1'b0;
        #1;
        check("mid reset y tracks a", 64'(bus_b.y), 64'h1);

        edge_step();
        check("reset held across edge", 64'(bus_b.y_q), 64'h1);
        rst_n = 1'b1;
        edge_step();
        check("first edge after release y_q", 64'(bus_b.y_q), 64'h1);
        check("first edge after release out_valid", 64'(bus_b.out_valid), 64'h1);
        check_base_cnts("first edge after release", 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nand_gate

// File: doc/nand_gate.md
Name: nand_gate

Overview:
- Bitwise NAND primitive with a registered copy of the result and per-pattern input coverage counters.
- The combinational output y = ~(a & b) is usable standalone; the clocked side adds one pipeline stage and saturating hit counters for the four lane-0 input patterns.
- Used as a leaf cell in logic labs and as a self-checking gate wrapper in larger datapaths.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q (bitwise operation per lane).
- CNT_W, 16, width of each pattern-hit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path and counters.
- clr_cnt  input  1  synchronous clear of all pattern counters.
- y  output  WIDTH  combinational ~(a & b).
- y_q  output  WIDTH  registered NAND result.
- out_valid  output  1  in_valid delayed one cycle.
- cnt_00  output  CNT_W  hits with {a[0],b[0]} = 00.
- cnt_01  output  CNT_W  hits with {a[0],b[0]} = 01.
- cnt_10  output  CNT_W  hits with {a[0],b[0]} = 10.
- cnt_11  output  CNT_W  hits with {a[0],b[0]} = 11.

Behaviour:
- y:
  - Purely combinational, zero latency: y[i] = ~(a[i] & b[i]) for every lane.
  - Independent of clk, rst_n, in_valid and clr_cnt.
  - Valid whenever a and b are known, including during reset.
- Reset: rst_n low asynchronously forces y_q = all ones, out_valid = 0 and all counters = 0. All of these hold until the first rising clk edge after rst_n is released.
- Registered path:
  - y_q loads ~(a & b) on each rising edge where in_valid = 1 and holds otherwise.
  - out_valid <= in_valid every edge.
  - Latency 1 cycle; back-to-back valid inputs accepted every cycle with no stall.
- Counters:
  - On a rising edge with in_valid = 1, the counter selected by {a[0],b[0]} increments by 1.
  - Saturates at 2^CNT_W − 1; no wrap.
  - Only one counter changes per cycle.
- clr_cnt:
  - clr_cnt = 1 zeroes all four counters at the edge.
  - It has priority over a simultaneous increment: that cycle's hit is dropped.
  - It does not affect y_q or out_valid.
- Reset mid-operation: in-flight y_q/out_valid are discarded and counters lose their history; y still tracks the inputs.
- X-handling: unknown a/b propagate X on y. With in_valid = 1, no counter increments when a[0] or b[0] is unknown.

Decomposition:
- Shared package nand_pkg holds:
  - default constants (DEF_WIDTH = 1, DEF_CNT_W = 16);
  - a 2-bit pattern enum PAT_00/01/10/11 used to index counters.
- One natural sub-module: nand_sat_counter, a CNT_W saturating counter with inc, clr and async reset. It is instantiated four times.
- The NAND lanes and the output register stay inline in nand_gate.

Test Plan:
- Truth table, WIDTH = 1, in_valid = 0:
  - Apply a,b = 00, 01, 10, 11, each held 10 ns.
  - y = 1, 1, 1, 0 within the same delta.
  - y_q stays 1 and counters stay 0.
- Registered path:
  - rst_n = 0 → y_q = 1, out_valid = 0 immediately, without a clock edge.
  - After release, drive in_valid = 1 with a = 1, b = 1 → next edge y_q = 0, out_valid = 1.
  - Then a = 0, b = 1 → y_q = 1 the following edge.
- Coverage:
  - Stream 00, 01, 10, 11, 11 with in_valid = 1 → cnt_00 = 1, cnt_01 = 1, cnt_10 = 1, cnt_11 = 2.
  - Then assert clr_cnt alongside pattern 00 → all four counters = 0.
- Saturation, CNT_W = 2:
  - Five cycles of pattern 10 → cnt_10 sequence 1, 2, 3, 3, 3.
- Wide operands, WIDTH = 8:
  - a = 8'hF0, b = 8'hCC → y = 8'h3F.
  - With in_valid = 1, y_q = 8'h3F after one edge, and cnt_00 increments (lane 0 = 0,0).
- Async reset mid-stream:
  - Assert rst_n low between edges while in_valid = 1 → outputs reset immediately.
  - y continues to follow a/b throughout.
